// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO round-robin arbiter.
// The optional MIDI_MSG_LOCK_EN build uses the MIDI byte-class thresholds below.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    POP     = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
  localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;

  // Index width for n items. Never returns 0, so a single-bit index always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester above ptr, wrapping N-1 -> 0.
// With mask_en set only req[mask_idx] may win.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mask_en,
  input  logic [IW-1:0] mask_idx,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0]  eff_req;
  logic [IW-1:0] idx;

  // NOTE: every variable written in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    eff_req = req;
    if (mask_en) begin
      eff_req           = '0;
      eff_req[mask_idx] = req[mask_idx];
    end

    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    // Walk from the farthest candidate to the nearest; the last hit is the highest priority.
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (eff_req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of N byte FIFOs into one registered, ack-held output slot.
// Define MIDI_MSG_LOCK_EN to keep MIDI messages from one source contiguous.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  N       = 4,
  parameter int  WIDTH   = 8,
  parameter int  LOCK_TO = 255,
  localparam int IW      = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       src_nempty,
  input  logic [N*WIDTH-1:0] src_data,
  output logic [N-1:0]       src_pop,
  output logic [WIDTH-1:0]   out_data,
  output logic [IW-1:0]      out_src,
  output logic               out_d_rdy,
  input  logic               out_ack
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("fifo_rr_arbiter: N must be 2..8");
  end
  if (LOCK_TO < 1 || LOCK_TO > 255) begin : g_bad_lock_to
    $error("fifo_rr_arbiter: LOCK_TO must be 1..255");
  end

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      out_src_q, out_src_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  logic [WIDTH-1:0]   src_arr [N];
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic               mask_en;
  logic [IW-1:0]      mask_idx;
  logic               cap_fire;
  logic [WIDTH-1:0]   cap_data;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req      (src_nempty),
    .ptr      (rr_ptr_q),
    .mask_en  (mask_en),
    .mask_idx (mask_idx),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // A grant is only honoured if its FIFO is still non-empty in the POP cycle.
  assign cap_fire = (state_q == POP) && src_nempty[grant_q];
  assign cap_data = src_arr[grant_q];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= IW'(N - 1);
      grant_q    <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      ARB: begin
        if (gnt_vld) begin
          state_d = POP;
          grant_d = gnt_idx;
        end
      end
      POP:     state_d = cap_fire ? PRESENT : ARB;
      PRESENT: if (out_ack) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    if (cap_fire) begin
      rr_ptr_d   = grant_q;
      out_data_d = cap_data;
      out_src_d  = grant_q;
    end
  end

  always_comb begin
    src_pop = '0;
    if (cap_fire) src_pop[grant_q] = 1'b1;
    out_d_rdy = (state_q == PRESENT);
  end

  assign out_data = out_data_q;
  assign out_src  = out_src_q;

`ifdef MIDI_MSG_LOCK_EN
  if (WIDTH != 8) begin : g_bad_width
    $error("fifo_rr_arbiter: WIDTH must be 8 with message lock");
  end

  logic          lock_q, lock_d;
  logic [IW-1:0] lock_src_q, lock_src_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          is_status;

  // Realtime bytes fall outside the status window and leave the lock untouched.
  assign is_status = (cap_data >= MIDI_STATUS_MIN) && (cap_data < MIDI_RT_MIN);

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    to_cnt_d   = to_cnt_q;
    if (cap_fire) begin
      if (lock_q && (grant_q == lock_src_q)) to_cnt_d = '0;
      if (is_status) begin
        lock_d     = 1'b1;
        lock_src_d = grant_q;
        to_cnt_d   = '0;
      end
    end else if ((state_q == ARB) && lock_q && !src_nempty[lock_src_q]) begin
      if (to_cnt_q == 8'(LOCK_TO - 1)) begin
        lock_d   = 1'b0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_src_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign mask_en  = lock_q;
  assign mask_idx = lock_src_q;
`else
  assign mask_en  = 1'b0;
  assign mask_idx = '0;
`endif

endmodule
